// File: rtl/branch_unit.sv
// Branch resolution and 2-bit-counter prediction unit; results are registered one cycle after EX.
// Optional feature macro: BRANCH_LINK_EN enables bltzal/bgezal as link-form branches.
module branch_unit #(
   parameter int         BHT_DEPTH = 64,
   parameter int         XLEN      = 32,
   parameter logic [1:0] INIT_CNT  = 2'b01
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   input  logic            ex_valid,
   input  logic [5:0]      ex_opcode,
   input  logic [4:0]      ex_rt_field,
   input  logic [15:0]     ex_imm,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_rs_val,
   input  logic [XLEN-1:0] ex_rt_val,
   input  logic            ex_pred_taken,
   input  logic            flush,
   output logic            res_valid,
   output logic            res_is_branch,
   output logic            res_taken,
   output logic [XLEN-1:0] res_target,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc,
   output logic            res_link,
   output logic [XLEN-1:0] link_addr
);

   localparam int IW = $clog2(BHT_DEPTH);

   logic [1:0]             bht [BHT_DEPTH];
   logic [IW-1:0]          if_idx;
   logic [IW-1:0]          ex_idx;
   logic signed [XLEN-1:0] rs_s;
   logic                   is_branch;
   logic                   is_link;
   logic                   taken;
   logic                   accept;
   logic                   train;
   logic [XLEN-1:0]        offset;
   logic [XLEN-1:0]        target;
   logic [XLEN-1:0]        seq_pc;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
      if (up)
         return (cnt == 2'b11) ? cnt : cnt + 2'd1;
      else
         return (cnt == 2'b00) ? cnt : cnt - 2'd1;
   endfunction

   assign if_idx     = if_pc[IW+1:2];
   assign ex_idx     = ex_pc[IW+1:2];
   // Same-cycle training is not visible here until after the edge.
   assign pred_taken = bht[if_idx][1];

   assign rs_s   = ex_rs_val;
   assign offset = {{(XLEN-18){ex_imm[15]}}, ex_imm, 2'b00};
   assign seq_pc = ex_pc + XLEN'(4);
   assign target = seq_pc + offset;
   assign accept = ex_valid & ~flush;
   assign train  = accept & is_branch;

   always_comb begin
      is_branch = 1'b0;
      is_link   = 1'b0;
      taken     = 1'b0;
      unique case (ex_opcode)
         6'h04: begin is_branch = 1'b1; taken = (ex_rs_val == ex_rt_val); end
         6'h05: begin is_branch = 1'b1; taken = (ex_rs_val != ex_rt_val); end
         6'h06: begin is_branch = 1'b1; taken = (rs_s <= 0); end
         6'h07: begin is_branch = 1'b1; taken = (rs_s > 0); end
         6'h01: begin
            unique case (ex_rt_field)
               5'b00000: begin is_branch = 1'b1; taken = (rs_s < 0); end
               5'b00001: begin is_branch = 1'b1; taken = (rs_s >= 0); end
`ifdef BRANCH_LINK_EN
               5'b10000: begin is_branch = 1'b1; is_link = 1'b1; taken = (rs_s < 0); end
               5'b10001: begin is_branch = 1'b1; is_link = 1'b1; taken = (rs_s >= 0); end
`endif
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= INIT_CNT;
      end else if (train) begin
         bht[ex_idx] <= sat_update(bht[ex_idx], taken);
      end
   end

   // EX -> result register boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid     <= 1'b0;
         res_is_branch <= 1'b0;
         res_taken     <= 1'b0;
         mispredict    <= 1'b0;
         res_target    <= '0;
         redirect_pc   <= '0;
         link_addr     <= '0;
      end else begin
         res_valid     <= accept;
         res_is_branch <= train;
         res_taken     <= train & taken;
         mispredict    <= train & (taken != ex_pred_taken);
         if (accept) begin
            res_target  <= target;
            redirect_pc <= taken ? target : seq_pc;
            link_addr   <= ex_pc + XLEN'(8);
         end
      end
   end

`ifdef BRANCH_LINK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) res_link <= 1'b0;
      else        res_link <= train & is_link;
   end
`else
   assign res_link = 1'b0;
   logic unused_link;
   assign unused_link = is_link;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Randomized self-checking bench for branch_unit against a behavioural counter-table model.
module tb_branch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic        ex_valid;
   logic [5:0]  ex_opcode;
   logic [4:0]  ex_rt_field;
   logic [15:0] ex_imm;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs_val;
   logic [31:0] ex_rt_val;
   logic        ex_pred_taken;
   logic        flush;
   logic        res_valid;
   logic        res_is_branch;
   logic        res_taken;
   logic [31:0] res_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        res_link;
   logic [31:0] link_addr;

   int checks = 0;
   int errors = 0;
   int cnt [64];

   branch_unit dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rt_field(ex_rt_field),
      .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
      .ex_pred_taken(ex_pred_taken), .flush(flush), .res_valid(res_valid),
      .res_is_branch(res_is_branch), .res_taken(res_taken), .res_target(res_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc), .res_link(res_link),
      .link_addr(link_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      return (pc / 4) % 64;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) cnt[i] = 1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},  {31'd0, res_valid}, 32'd0);
      check({tag, "_isbr"},   {31'd0, res_is_branch}, 32'd0);
      check({tag, "_taken"},  {31'd0, res_taken}, 32'd0);
      check({tag, "_mis"},    {31'd0, mispredict}, 32'd0);
      check({tag, "_link"},   {31'd0, res_link}, 32'd0);
      check({tag, "_target"}, res_target, 32'd0);
      check({tag, "_redir"},  redirect_pc, 32'd0);
      check({tag, "_laddr"},  link_addr, 32'd0);
   endtask

   // Drives one EX cycle, checks the prediction before the edge and results after it.
   task automatic issue(input logic [5:0] op, input logic [4:0] rtf, input logic [15:0] imm,
                        input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                        input logic pred, input logic fl, input logic vld, input logic [31:0] ipc);
      bit br, tk, lk, acc;
      logic [31:0] tgt;
      ex_opcode = op; ex_rt_field = rtf; ex_imm = imm; ex_pc = pc;
      ex_rs_val = rs; ex_rt_val = rt; ex_pred_taken = pred; flush = fl;
      ex_valid = vld; if_pc = ipc;
      #1;
      check("pred_lookup", {31'd0, pred_taken}, (cnt[idx_of(ipc)] >= 2) ? 32'd1 : 32'd0);
      br = 0; tk = 0; lk = 0;
      if (op == 6'h04) begin br = 1; tk = (rs == rt); end
      else if (op == 6'h05) begin br = 1; tk = (rs != rt); end
      else if (op == 6'h06) begin br = 1; tk = ($signed(rs) <= 0); end
      else if (op == 6'h07) begin br = 1; tk = ($signed(rs) > 0); end
      else if (op == 6'h01 && rtf == 5'd0) begin br = 1; tk = ($signed(rs) < 0); end
      else if (op == 6'h01 && rtf == 5'd1) begin br = 1; tk = ($signed(rs) >= 0); end
`ifdef BRANCH_LINK_EN
      else if (op == 6'h01 && rtf == 5'd16) begin br = 1; lk = 1; tk = ($signed(rs) < 0); end
      else if (op == 6'h01 && rtf == 5'd17) begin br = 1; lk = 1; tk = ($signed(rs) >= 0); end
`endif
      acc = vld && !fl;
      tgt = pc + 32'd4 + ({{16{imm[15]}}, imm} << 2);
      @(posedge clk);
      #1;
      check("res_valid", {31'd0, res_valid}, {31'd0, acc});
      check("res_is_branch", {31'd0, res_is_branch}, {31'd0, acc && br});
      check("res_taken", {31'd0, res_taken}, {31'd0, acc && br && tk});
      check("mispredict", {31'd0, mispredict}, {31'd0, acc && br && (tk != pred)});
      check("res_link", {31'd0, res_link}, {31'd0, acc && lk});
      if (acc) begin
         check("res_target", res_target, tgt);
         check("redirect_pc", redirect_pc, tk ? tgt : pc + 32'd4);
         check("link_addr", link_addr, pc + 32'd8);
      end
      if (acc && br) begin
         if (tk && cnt[idx_of(pc)] < 3) cnt[idx_of(pc)]++;
         else if (!tk && cnt[idx_of(pc)] > 0) cnt[idx_of(pc)]--;
      end
   endtask

   task automatic random_ops(input int n);
      logic [5:0]  op;
      logic [4:0]  rtf;
      logic [31:0] pc, rs, rt, ipc;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 6))
            0: op = 6'h04; 1: op = 6'h05; 2: op = 6'h06; 3: op = 6'h07;
            4, 5: op = 6'h01;
            default: op = 6'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0: rtf = 5'd0; 1: rtf = 5'd1; 2: rtf = 5'd16; 3: rtf = 5'd17;
            default: rtf = 5'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0: rs = 32'd0; 1: rs = 32'd1; 2: rs = 32'hFFFF_FFFF; 3: rs = 32'h8000_0000;
            default: rs = $urandom;
         endcase
         rt  = ($urandom_range(0, 1) == 0) ? rs : $urandom;
         pc  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : ($urandom_range(0, 127) << 2);
         ipc = ($urandom_range(0, 1) == 0) ? pc : ($urandom_range(0, 127) << 2);
         issue(op, rtf, 16'($urandom), pc, rs, rt, 1'($urandom), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 5) != 0), ipc);
      end
   endtask

   initial begin
      rst_n = 1'b0; ex_valid = 0; ex_opcode = 0; ex_rt_field = 0; ex_imm = 0; ex_pc = 0;
      ex_rs_val = 0; ex_rt_val = 0; ex_pred_taken = 0; flush = 0; if_pc = 32'h0;
      model_reset();
      #1;
      check("rst_pred_0", {31'd0, pred_taken}, 32'd0);
      if_pc = 32'hFC;
      #1;
      check("rst_pred_fc", {31'd0, pred_taken}, 32'd0);
      check_all_zero("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_valid", {31'd0, res_valid}, 32'd0);

      // Directed: first taken beq, saturation, then a not-taken resolve.
      issue(6'h04, 0, 16'h0004, 32'h100, 5, 5, 0, 0, 1, 32'h100);
      issue(6'h00, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h100);
      for (int i = 0; i < 3; i++) issue(6'h04, 0, 16'h0004, 32'h100, 5, 5, 1, 0, 1, 32'h100);
      issue(6'h04, 0, 16'h0004, 32'h100, 5, 6, 1, 0, 1, 32'h100);
      issue(6'h00, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h100);
      // Directed: REGIMM and blez/bgtz conditions with a negative offset.
      issue(6'h01, 5'd0, 16'hFFFF, 32'h200, 32'h8000_0000, 0, 0, 0, 1, 32'h200);
      issue(6'h01, 5'd1, 16'hFFFF, 32'h200, 0, 0, 0, 0, 1, 32'h200);
      issue(6'h06, 0, 16'hFFFF, 32'h200, 0, 0, 0, 0, 1, 32'h200);
      issue(6'h07, 0, 16'hFFFF, 32'h200, 0, 0, 1, 0, 1, 32'h200);
      // Directed: flushed beq does not train; same-index lookup.
      issue(6'h04, 0, 16'h0004, 32'h140, 7, 7, 0, 1, 1, 32'h140);
      issue(6'h00, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h140);
      // Directed: link-form encoding.
      issue(6'h01, 5'd17, 16'h0010, 32'h300, 1, 0, 0, 0, 1, 32'h300);
      issue(6'h01, 5'd16, 16'h0010, 32'h304, 1, 0, 1, 0, 1, 32'h304);

      random_ops(400);

      // Asynchronous reset in the middle of a cycle.
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all_zero("async_rst");
      if_pc = 32'h100;
      #1;
      check("async_rst_pred", {31'd0, pred_taken}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      random_ops(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
